// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// Holds the FSM state encoding, memory op codes and the default memory size.
package mem_arb_pkg;

  localparam int DEFAULT_MEM_SIZE = 96;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  localparam logic [1:0] OP_READ = 2'd0;
  localparam logic [1:0] OP_WR1  = 2'd1;
  localparam logic [1:0] OP_WR2  = 2'd2;
  localparam logic [1:0] OP_WR4  = 2'd3;

  // Number of bytes an access touches; reads always fetch a whole word.
  function automatic int op_bytes(input logic [1:0] op);
    case (op)
      OP_WR1:  return 1;
      OP_WR2:  return 2;
      default: return 4;
    endcase
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Two-way round-robin arbiter. On a tie the requester not granted most
// recently wins; last_grant only moves when the grant is actually accepted.
module rr_arbiter (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] grant
);

  logic last_grant;

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      last_grant <= 1'b1;
    end else if (accept) begin
      last_grant <= grant[1];
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter in front of a combinational-read byte memory.
// Each access runs IDLE (accept) -> ACCESS (memory op) -> RESP (response pulse).
//
// Handshake: a request transfers on a cycle where reqN_valid and reqN_ready are
// both high; ready is only offered in IDLE, to the arbiter's single grant, and
// never while reset is asserted. Once transferred, the requester sees exactly
// one respN_valid pulse two cycles later, unless reset aborts the access.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_SIZE = DEFAULT_MEM_SIZE,
  parameter int ADDR_W   = 10
) (
  input  logic                clock,
  input  logic                reset,

  input  logic                req0_valid,
  input  logic [1:0]          req0_op,
  input  logic [ADDR_W-1:0]   req0_addr,
  input  logic [31:0]         req0_wdata,
  output logic                req0_ready,
  output logic                resp0_valid,
  output logic [31:0]         resp0_rdata,
  output logic                resp0_err,

  input  logic                req1_valid,
  input  logic [1:0]          req1_op,
  input  logic [ADDR_W-1:0]   req1_addr,
  input  logic [31:0]         req1_wdata,
  output logic                req1_ready,
  output logic                resp1_valid,
  output logic [31:0]         resp1_rdata,
  output logic                resp1_err,

  output logic [2:0]          em_control,
  output logic [4*ADDR_W-1:0] em_address,
  output logic [7:0]          em_dw0,
  output logic [7:0]          em_dw1,
  output logic [7:0]          em_dw2,
  output logic [7:0]          em_dw3,
  input  logic [31:0]         em_read,

  output logic [1:0]          dbg_state
);

  localparam logic [1:0] IDLE   = ST_IDLE;
  localparam logic [1:0] ACCESS = ST_ACCESS;
  localparam logic [1:0] RESP   = ST_RESP;

  logic [1:0]        state_q;
  logic [1:0]        grant;
  logic              accept;
  logic              sel;
  logic [1:0]        sel_op;
  logic [ADDR_W-1:0] sel_addr;
  logic [31:0]       sel_wdata;
  logic              sel_err;
  logic [ADDR_W-1:0] byte_addr;
  logic              gnt_q;
  logic              err_q;

  rr_arbiter u_arb (
    .clock  (clock),
    .reset  (reset),
    .req    ({req1_valid, req0_valid}),
    .accept (accept),
    .grant  (grant)
  );

  assign accept    = (state_q == IDLE) && !reset && (grant != 2'b00);
  assign sel       = grant[1];
  assign sel_op    = sel ? req1_op    : req0_op;
  assign sel_addr  = sel ? req1_addr  : req0_addr;
  assign sel_wdata = sel ? req1_wdata : req0_wdata;

  assign req0_ready = accept && grant[0];
  assign req1_ready = accept && grant[1];

  // Out of range if any touched byte (after address wrap) lies beyond the memory.
  always_comb begin
    sel_err   = 1'b0;
    byte_addr = '0;
    for (int i = 0; i < 4; i++) begin
      byte_addr = sel_addr + ADDR_W'(i);
      if ((i < op_bytes(sel_op)) && (32'(byte_addr) >= MEM_SIZE)) begin
        sel_err = 1'b1;
      end
    end
  end

  // Reset masks the pulse combinationally so an abort in RESP is never seen.
  assign resp0_valid = (state_q == RESP) && !gnt_q && !reset;
  assign resp1_valid = (state_q == RESP) &&  gnt_q && !reset;
  assign resp0_err   = resp0_valid && err_q;
  assign resp1_err   = resp1_valid && err_q;
  assign dbg_state   = state_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      gnt_q       <= 1'b0;
      err_q       <= 1'b0;
      em_control  <= 3'd0;
      em_address  <= '0;
      em_dw0      <= 8'd0;
      em_dw1      <= 8'd0;
      em_dw2      <= 8'd0;
      em_dw3      <= 8'd0;
      resp0_rdata <= 32'd0;
      resp1_rdata <= 32'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q    <= ACCESS;
            gnt_q      <= sel;
            err_q      <= sel_err;
            em_control <= sel_err ? 3'd0 : {1'b0, sel_op};
            for (int i = 0; i < 4; i++) begin
              em_address[i*ADDR_W +: ADDR_W] <= sel_addr + ADDR_W'(i);
            end
            em_dw0 <= sel_wdata[7:0];
            em_dw1 <= sel_wdata[15:8];
            em_dw2 <= sel_wdata[23:16];
            em_dw3 <= sel_wdata[31:24];
          end
        end
        ACCESS: begin
          state_q    <= RESP;
          em_control <= 3'd0;
          if (gnt_q) begin
            resp1_rdata <= err_q ? 32'd0 : em_read;
          end else begin
            resp0_rdata <= err_q ? 32'd0 : em_read;
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q    <= IDLE;
          em_control <= 3'd0;
        end
      endcase
    end
  end

endmodule
